// File: rtl/mtm_alu_deserializer.sv
// Serial receiver for the ALU link: decodes 11-bit packets from sin and assembles
// B/A operand frames terminated by a command packet.
module mtm_alu_deserializer #(
  parameter int DATA_PACKETS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] b_out,
  output logic [31:0] a_out,
  output logic [7:0]  ctl_out,
  output logic        dataready,
  output logic        err_data,
  output logic        err_frame
);

  localparam int CW = $clog2(DATA_PACKETS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_PACKETS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_PACKETS + 1);

  typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, RESYNC} state_t;

  state_t          state, state_nxt;
  logic            type_q;
  logic [7:0]      byte_q;
  logic [2:0]      bit_cnt;
  logic [CW-1:0]   pkt_cnt;
  logic [63:0]     frame_q;
  logic            good_p, bad_p, ferr_p;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!sin) state_nxt = TYPE;
      TYPE:    state_nxt = DATA;
      DATA:    if (bit_cnt == 3'd0) state_nxt = STOP;
      STOP:    state_nxt = sin ? IDLE : RESYNC;
      RESYNC:  if (sin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pulses are staged through *_p so they rise one edge after the stop-bit sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      type_q    <= 1'b0;
      byte_q    <= '0;
      bit_cnt   <= '0;
      pkt_cnt   <= '0;
      frame_q   <= '0;
      good_p    <= 1'b0;
      bad_p     <= 1'b0;
      ferr_p    <= 1'b0;
      b_out     <= '0;
      a_out     <= '0;
      ctl_out   <= '0;
      dataready <= 1'b0;
      err_data  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      state     <= state_nxt;
      good_p    <= 1'b0;
      bad_p     <= 1'b0;
      ferr_p    <= 1'b0;
      dataready <= good_p;
      err_data  <= bad_p;
      err_frame <= ferr_p;
      case (state)
        TYPE: begin
          type_q  <= sin;
          bit_cnt <= 3'd7;
        end
        DATA: begin
          byte_q  <= {byte_q[6:0], sin};
          bit_cnt <= bit_cnt - 3'd1;
        end
        STOP: begin
          if (sin) begin
            if (type_q) begin
              if (pkt_cnt == CNT_FULL) begin
                b_out   <= frame_q[63:32];
                a_out   <= frame_q[31:0];
                ctl_out <= byte_q;
                good_p  <= 1'b1;
              end else begin
                bad_p <= 1'b1;
              end
              pkt_cnt <= '0;
              frame_q <= '0;
            end else begin
              frame_q <= {frame_q[55:0], byte_q};
              if (pkt_cnt != CNT_SAT) pkt_cnt <= pkt_cnt + CW'(1);
            end
          end else begin
            ferr_p  <= 1'b1;
            pkt_cnt <= '0;
            frame_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Self-checking bench for mtm_alu_deserializer: table of frames plus hand-written
// framing-error and reset sequences, checked through an expected-result queue.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] b_out, a_out;
  logic [7:0]  ctl_out;
  logic        dataready, err_data, err_frame;

  mtm_alu_deserializer #(.DATA_PACKETS(8)) dut (
    .clk(clk), .rst(rst), .sin(sin),
    .b_out(b_out), .a_out(a_out), .ctl_out(ctl_out),
    .dataready(dataready), .err_data(err_data), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  localparam int K_DR = 0;
  localparam int K_ED = 1;
  localparam int K_EF = 2;

  typedef struct {
    int          kind;
    logic [31:0] b;
    logic [31:0] a;
    logic [7:0]  ctl;
    int          cyc;
  } exp_t;

  typedef struct {
    int          ndata;
    logic [79:0] data;
    logic [7:0]  cmd;
    int          gap;
    int          kind;
    logic [31:0] b;
    logic [31:0] a;
    logic [7:0]  ctl;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the head of the queue, one cycle wide, one-hot.
  logic prev_pulse = 1'b0;
  logic any_pulse;
  int   kind_act;
  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst) begin
      any_pulse = dataready | err_data | err_frame;
      if (any_pulse) begin
        chk("one_hot", 64'(int'(dataready) + int'(err_data) + int'(err_frame)), 64'd1);
        chk("pulse_width", 64'(prev_pulse), 64'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          e_mon    = sb.pop_front();
          kind_act = dataready ? K_DR : (err_data ? K_ED : K_EF);
          chk("kind", 64'(kind_act), 64'(e_mon.kind));
          chk("latency_cycle", 64'(cyc), 64'(e_mon.cyc));
          chk("b_out", 64'(b_out), 64'(e_mon.b));
          chk("a_out", 64'(a_out), 64'(e_mon.a));
          chk("ctl_out", 64'(ctl_out), 64'(e_mon.ctl));
        end
      end
      prev_pulse = any_pulse;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  // Expected pulse cycle: stop bit sampled on the next edge, pulse on the one after.
  task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop,
                          input bit push, input exp_t e);
    exp_t ee;
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    if (push) begin
      ee     = e;
      ee.cyc = cyc + 2;
      sb.push_back(ee);
    end
    send_bit(stop);
  endtask

  function automatic vec_t mk(input int n, input logic [79:0] d, input logic [7:0] c,
                              input int g, input int k, input logic [31:0] b,
                              input logic [31:0] a, input logic [7:0] ctl);
    vec_t v;
    v.ndata = n; v.data = d; v.cmd = c; v.gap = g;
    v.kind = k; v.b = b; v.a = a; v.ctl = ctl;
    return v;
  endfunction

  task automatic send_frame(input vec_t v);
    exp_t e;
    logic [79:0] d;
    d = v.data;
    for (int i = 0; i < v.ndata; i++) begin
      send_pkt(1'b0, d[79:72], 1'b1, 1'b0, e);
      d = d << 8;
      idle(v.gap);
    end
    e.kind = v.kind; e.b = v.b; e.a = v.a; e.ctl = v.ctl; e.cyc = 0;
    send_pkt(1'b1, v.cmd, 1'b1, 1'b1, e);
    idle(v.gap);
  endtask

  vec_t vecs[7];
  exp_t ef;

  initial begin
    vecs[0] = mk(8, 80'h00000002_00000003_0000, 8'h80, 0,  K_DR, 32'h00000002, 32'h00000003, 8'h80);
    vecs[1] = mk(5, 80'h11223344_55_0000000000, 8'h80, 0,  K_ED, 32'h00000002, 32'h00000003, 8'h80);
    vecs[2] = mk(9, 80'h01020304_05060708_09_00, 8'h7E, 0, K_ED, 32'h00000002, 32'h00000003, 8'h80);
    vecs[3] = mk(8, 80'hDEADBEEF_01234567_0000, 8'h01, 0,  K_DR, 32'hDEADBEEF, 32'h01234567, 8'h01);
    vecs[4] = mk(8, 80'h00000002_00000003_0000, 8'h80, 20, K_DR, 32'h00000002, 32'h00000003, 8'h80);
    vecs[5] = mk(0, 80'h0, 8'hFF, 0,                        K_ED, 32'h00000002, 32'h00000003, 8'h80);
    vecs[6] = mk(8, 80'hA55AFF00_C33C8118_0000, 8'h55, 3,  K_DR, 32'hA55AFF00, 32'hC33C8118, 8'h55);

    rst = 1'b1;
    sin = 1'b1;
    #12;
    chk("rst_b_out", 64'(b_out), 64'd0);
    chk("rst_a_out", 64'(a_out), 64'd0);
    chk("rst_ctl_out", 64'(ctl_out), 64'd0);
    chk("rst_pulses", 64'({dataready, err_data, err_frame}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(3);

    for (int v = 0; v < 7; v++) send_frame(vecs[v]);

    // Framing error on the 3rd data packet, then sin held low before recovery.
    send_pkt(1'b0, 8'h10, 1'b1, 1'b0, ef);
    send_pkt(1'b0, 8'h20, 1'b1, 1'b0, ef);
    ef.kind = K_EF; ef.b = 32'hA55AFF00; ef.a = 32'hC33C8118; ef.ctl = 8'h55; ef.cyc = 0;
    send_pkt(1'b0, 8'h30, 1'b0, 1'b1, ef);
    repeat (5) send_bit(1'b0);
    idle(2);
    send_frame(mk(8, 80'h11223344_55667788_0000, 8'h42, 0, K_DR, 32'h11223344, 32'h55667788, 8'h42));
    idle(3);

    // Reset asserted during the data bits of the 6th packet.
    for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'(8'h61 + i), 1'b1, 1'b0, ef);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_b_out", 64'(b_out), 64'd0);
    chk("midrst_a_out", 64'(a_out), 64'd0);
    chk("midrst_ctl_out", 64'(ctl_out), 64'd0);
    chk("midrst_pulses", 64'({dataready, err_data, err_frame}), 64'd0);
    sin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    send_frame(mk(0, 80'h0, 8'h33, 0, K_ED, 32'h0, 32'h0, 8'h00));
    send_frame(mk(8, 80'hCAFEF00D_0BADC0DE_0000, 8'h99, 0, K_DR, 32'hCAFEF00D, 32'h0BADC0DE, 8'h99));

    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
    idle(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
